array_frame_collector: RTL and testbench

Receive-side counterpart of the parameterized array-port blocks. It accepts a valid/ready word stream and collects up to DEPTH words into a registered unpacked-array output, out_array [DEPTH]. It then presents the whole frame with a valid/ready handshake. It sits between a serial producer and any consumer that takes an unpacked array port, for example an array input of width [WIDTH-1:0] and depth [DEPTH].

---
 rtl/array_frame_collector.sv | 104 ++++++++++
 tb/tb_array_frame_collector.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/array_frame_collector.sv
// rtl/array_frame_collector.sv - collects a valid/ready word stream into a registered unpacked-array frame
// Optional parity checking is enabled by defining ARRAY_FRAME_PARITY_EN.
module array_frame_collector #(
  parameter int DEPTH = 6,
  parameter int WIDTH = DEPTH + 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
`ifdef ARRAY_FRAME_PARITY_EN
  input  logic             in_par,
  output logic             out_par_err,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_array [DEPTH],
  output logic [CNT_W-1:0] out_count,
  output logic             out_short
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] idx;
  logic             accept;
  logic             wrap;
  logic             release_frame;

  assign in_ready      = (state == FILL);
  assign out_valid     = (state == HOLD);
  assign accept        = in_valid && (state == FILL);
  assign wrap          = accept && ((idx == LAST_IDX) || in_last);
  assign release_frame = (state == HOLD) && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      FILL:    if (wrap) next_state = HOLD;
      HOLD:    if (out_ready) next_state = FILL;
      default: next_state = FILL;
    endcase
  end

  // Release wipes the whole frame so unused elements of the next short frame read 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      out_count <= '0;
      out_short <= 1'b0;
      for (int i = 0; i < DEPTH; i++) out_array[i] <= '0;
    end else if (release_frame) begin
      idx       <= '0;
      out_count <= '0;
      out_short <= 1'b0;
      for (int i = 0; i < DEPTH; i++) out_array[i] <= '0;
    end else if (accept) begin
      out_array[idx] <= in_data;
      if (wrap) begin
        idx       <= '0;
        out_count <= idx + CNT_W'(1);
        out_short <= in_last && (idx != LAST_IDX);
      end else begin
        idx <= idx + CNT_W'(1);
      end
    end
  end

`ifdef ARRAY_FRAME_PARITY_EN
  logic par_acc;
  logic par_bad;

  assign par_bad = in_par != (^in_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_acc     <= 1'b0;
      out_par_err <= 1'b0;
    end else if (release_frame) begin
      par_acc     <= 1'b0;
      out_par_err <= 1'b0;
    end else if (accept) begin
      if (wrap) begin
        par_acc     <= 1'b0;
        out_par_err <= par_acc || par_bad;
      end else begin
        par_acc <= par_acc || par_bad;
      end
    end
  end
`endif

endmodule

// File: tb/tb_array_frame_collector.sv
// tb/tb_array_frame_collector.sv - scoreboard bench for array_frame_collector
// Directed frames first, then randomized frames against a queue-based reference.
module tb_array_frame_collector;

  localparam int DEPTH = 6;
  localparam int WIDTH = DEPTH + 2;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int TMO   = 200;

  typedef logic [DEPTH-1:0][WIDTH-1:0] frame_t;

  typedef struct {
    frame_t arr;
    int     cnt;
    bit     sh;
    bit     perr;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic             in_par = 1'b0;
  logic             out_par_err;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_array [DEPTH];
  logic [CNT_W-1:0] out_count;
  logic             out_short;

  logic man_ready = 1'b0;
  logic rnd_ready = 1'b0;
  logic cons_en   = 1'b0;
  int   checks    = 0;
  int   errors    = 0;
  exp_t sb [$];

  assign out_ready = cons_en ? rnd_ready : man_ready;

  array_frame_collector #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
`ifdef ARRAY_FRAME_PARITY_EN
    .in_par(in_par),
    .out_par_err(out_par_err),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_array(out_array),
    .out_count(out_count),
    .out_short(out_short)
  );

`ifndef ARRAY_FRAME_PARITY_EN
  assign out_par_err = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic frame_t cur_frame();
    frame_t f;
    for (int i = 0; i < DEPTH; i++) f[i] = out_array[i];
    return f;
  endfunction

  function automatic bit all_zero();
    for (int i = 0; i < DEPTH; i++) if (out_array[i] !== '0) return 1'b0;
    return 1'b1;
  endfunction

  // Reference: first n words land in order, everything else is zero.
  task automatic push_exp(input int n, input frame_t words, input int bad_idx);
    exp_t e;
    for (int i = 0; i < DEPTH; i++) e.arr[i] = (i < n) ? words[i] : '0;
    e.cnt  = n;
    e.sh   = (n < DEPTH);
    e.perr = (bad_idx >= 0) && (bad_idx < n);
    sb.push_back(e);
  endtask

  task automatic send_word(input logic [WIDTH-1:0] d, input bit last, input bit bad_par);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_par   = (^d) ^ bad_par;
    @(negedge clk);
    while (!in_ready && t < TMO) begin
      @(negedge clk);
      t++;
    end
    if (t >= TMO) chk("in_ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input int n, input frame_t words, input bit last_on_full,
                            input int max_gap, input int bad_idx);
    push_exp(n, words, bad_idx);
    for (int i = 0; i < n; i++) begin
      send_word(words[i], (i == n - 1) && ((n < DEPTH) || last_on_full), (i == bad_idx));
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(posedge clk);
      #1;
    end
  endtask

  task automatic release_frame();
    man_ready = 1'b1;
    @(posedge clk);
    #1;
    man_ready = 1'b0;
    chk("release_out_valid_low", out_valid, 0);
    chk("release_in_ready_high", in_ready, 1);
    chk("release_count_cleared", out_count, 0);
    chk("release_array_cleared", all_zero(), 1);
  endtask

  // Monitor: every accepted frame is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_frame", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("frame_array", cur_frame(), e.arr);
        chk("frame_count", out_count, e.cnt);
        chk("frame_short", out_short, e.sh);
        chk("frame_in_ready_low", in_ready, 0);
`ifdef ARRAY_FRAME_PARITY_EN
        chk("frame_par_err", out_par_err, e.perr);
`endif
      end
    end
  end

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    frame_t w;
    int t;

    #12;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_count", out_count, 0);
    chk("reset_short", out_short, 0);
    chk("reset_array", all_zero(), 1);
    chk("reset_par_err", out_par_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full frame, back-to-back, consumer stalled.
    for (int i = 0; i < DEPTH; i++) w[i] = WIDTH'(8'h11 * (i + 1));
    push_exp(DEPTH, w, -1);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) chk("pre_last_out_valid", out_valid, 0);
      send_word(w[i], 1'b0, 1'b0);
    end
    chk("full_out_valid", out_valid, 1);
    chk("full_in_ready", in_ready, 0);
    chk("full_count", out_count, DEPTH);
    chk("full_short", out_short, 0);

    // Backpressure with a word pending on the input.
    in_valid = 1'b1;
    in_data  = 8'hFF;
    repeat (10) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_out_valid", out_valid, 1);
    chk("bp_array", cur_frame(), w);
    chk("bp_count", out_count, DEPTH);
    release_frame();

    // Short frame.
    w = '0;
    w[0] = 8'hA1;
    w[1] = 8'hB2;
    send_frame(2, w, 1'b0, 0, -1);
    chk("short_out_valid", out_valid, 1);
    chk("short_flag", out_short, 1);
    chk("short_count", out_count, 2);
    chk("short_tail_zero", {out_array[2], out_array[3], out_array[4], out_array[5]}, 0);
    release_frame();

    // Gapped input, in_last on the final element keeps out_short low.
    for (int i = 0; i < DEPTH; i++) w[i] = WIDTH'($urandom);
    push_exp(DEPTH, w, -1);
    for (int i = 0; i < DEPTH; i++) begin
      send_word(w[i], i == DEPTH - 1, 1'b0);
      @(posedge clk);
      #1;
    end
    chk("gap_count", out_count, DEPTH);
    chk("gap_short", out_short, 0);
    release_frame();

    // Asynchronous reset mid-frame.
    for (int i = 0; i < 3; i++) send_word(WIDTH'(8'hC0 + i), 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_array", all_zero(), 1);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_count", out_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < DEPTH; i++) w[i] = WIDTH'(8'h30 + i);
    send_frame(DEPTH, w, 1'b0, 0, -1);
    chk("postrst_first", out_array[0], 8'h30);
    release_frame();

`ifdef ARRAY_FRAME_PARITY_EN
    for (int i = 0; i < DEPTH; i++) w[i] = WIDTH'($urandom);
    send_frame(DEPTH, w, 1'b0, 0, 3);
    chk("par_err_set", out_par_err, 1);
    release_frame();
    chk("par_err_cleared", out_par_err, 0);
    send_frame(DEPTH, w, 1'b0, 0, -1);
    chk("par_err_clean", out_par_err, 0);
    release_frame();
`endif

    // Randomized frames with a randomly stalling consumer.
    cons_en = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int n;
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < DEPTH; i++) w[i] = WIDTH'($urandom);
      send_frame(n, w, $urandom_range(0, 1) == 1, 2,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1)) : -1);
    end

    t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
